// File: rtl/bw_r_frf_pkg.sv
// Shared constants for the multi-read-port FP register file:
// default geometry, FSM state encoding and half-select indices.
package bw_r_frf_pkg;

  localparam int unsigned HALF_W_DEF = 39;   // 32 data + 7 ECC
  localparam int unsigned DEPTH_DEF  = 128;
  localparam int unsigned ADDR_W_DEF = 7;
  localparam int unsigned NUM_RD_DEF = 2;

  // Half-select indices into wr_en and the {high, low} word layout
  localparam int unsigned HI = 1;
  localparam int unsigned LO = 0;

  // Init-sequencer states
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/bw_r_frf_bank.sv
// One half-array of the register file: a single write port and NUM_RD
// registered read ports with same-cycle write-to-read bypass.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (clears read regs)
//   we_i, waddr_i,      write enable / address / data (already qualified)
//   wdata_i
//   re_i                per-port read enable; disabled ports return 0
//   raddr_i             port p address at [p*ADDR_W +: ADDR_W]
//   rdata_o             port p data at [p*W +: W], registered
module bw_r_frf_bank
  import bw_r_frf_pkg::*;
#(
  parameter int unsigned W      = HALF_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [NUM_RD-1:0]        re_i,
  input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
  output logic [NUM_RD*W-1:0]      rdata_o
);

  logic [W-1:0]        mem_q [DEPTH];
  logic [NUM_RD*W-1:0] rdata_q;
  logic [NUM_RD*W-1:0] rdata_d;

  // Storage: no reset, the init sequencer zeroes it
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read mux; a read hitting the committing write sees the new data
  always_comb begin
    rdata_d = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (re_i[p]) begin
        if (we_i && (raddr_i[p*ADDR_W +: ADDR_W] == waddr_i)) begin
          rdata_d[p*W +: W] = wdata_i;
        end else begin
          rdata_d[p*W +: W] = mem_q[raddr_i[p*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bw_r_frf_mp.sv
// Multi-read-port FP register file with split high/low halves and a
// hardware init sequencer that zeroes the array after reset or on request.
// Ports:
//   rclk, rst     clock, synchronous active-high reset
//   init_req      re-run array zeroing (acted on only in READY)
//   rst_tri_en    write block, registered with the input stage
//   wr_en         half write enables [1]=high, [0]=low
//   wr_addr/data  write entry / {high, low} data
//   rd_en/addr    per-port read enable / address (port p at [p*ADDR_W +: ADDR_W])
//   rd_data       per-port registered data (port p at [p*2*HALF_W +: 2*HALF_W])
//   init_busy     high while the array is being zeroed
module bw_r_frf_mp
  import bw_r_frf_pkg::*;
#(
  parameter int unsigned HALF_W = HALF_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF
) (
  input  logic                       rclk,
  input  logic                       rst,
  input  logic                       init_req,
  input  logic                       rst_tri_en,
  input  logic [1:0]                 wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [2*HALF_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*2*HALF_W-1:0] rd_data,
  output logic                       init_busy
);

  localparam int unsigned DW = 2 * HALF_W;

  if (int'(DEPTH) != (1 << ADDR_W)) begin : g_bad_depth
    $error("bw_r_frf_mp: DEPTH must equal 2**ADDR_W");
  end
  if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_num_rd
    $error("bw_r_frf_mp: NUM_RD must be 1..4");
  end

  // Input stage (S1)
  logic                     tri_q;
  logic [1:0]               wr_en_q;
  logic [ADDR_W-1:0]        wr_addr_q;
  logic [DW-1:0]            wr_data_q;
  logic [NUM_RD-1:0]        rd_en_q;
  logic [NUM_RD*ADDR_W-1:0] rd_addr_q;

  always_ff @(posedge rclk) begin
    if (rst) begin
      tri_q     <= 1'b0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      tri_q     <= rst_tri_en;
      wr_en_q   <= wr_en;
      wr_addr_q <= wr_addr;
      wr_data_q <= wr_data;
      rd_en_q   <= rd_en;
      rd_addr_q <= rd_addr;
    end
  end

  // Init sequencer state
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [1:0]        bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DW-1:0]     bank_wdata;
  logic [NUM_RD-1:0] bank_re;

  // Next state plus write/read qualification; INIT owns the write port
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bank_we    = '0;
    bank_waddr = wr_addr_q;
    bank_wdata = wr_data_q;
    bank_re    = '0;
    if (state_q == ST_INIT) begin
      bank_we    = 2'b11;
      bank_waddr = cnt_q;
      bank_wdata = '0;
      cnt_d      = cnt_q + ADDR_W'(1);
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end
    end else begin
      bank_we = wr_en_q & {2{~tri_q}};
      bank_re = rd_en_q;
      if (init_req) begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    end
  end

  assign init_busy = (state_q == ST_INIT);

  logic [NUM_RD*HALF_W-1:0] half_rd [2];

  for (genvar h = 0; h < 2; h++) begin : g_half
    bw_r_frf_bank #(
      .W      (HALF_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD)
    ) u_bank (
      .clk_i   (rclk),
      .rst_i   (rst),
      .we_i    (bank_we[h]),
      .waddr_i (bank_waddr),
      .wdata_i (bank_wdata[h*HALF_W +: HALF_W]),
      .re_i    (bank_re),
      .raddr_i (rd_addr_q),
      .rdata_o (half_rd[h])
    );
  end

  // Reassemble {high, low} per read port
  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    assign rd_data[p*DW + HI*HALF_W +: HALF_W] = half_rd[HI][p*HALF_W +: HALF_W];
    assign rd_data[p*DW + LO*HALF_W +: HALF_W] = half_rd[LO][p*HALF_W +: HALF_W];
  end

endmodule

// File: tb/tb_bw_r_frf_mp.sv
// Self-checking bench for bw_r_frf_mp: directed vector table, hand-written
// init/reset sequences and random traffic against a behavioural model.
module tb_bw_r_frf_mp;

  localparam int unsigned HALF_W = 39;
  localparam int unsigned DEPTH  = 128;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned DW     = 2 * HALF_W;
  localparam int unsigned RW     = NUM_RD * DW;

  logic                     rclk = 1'b0;
  logic                     rst;
  logic                     init_req;
  logic                     rst_tri_en;
  logic [1:0]               wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DW-1:0]            wr_data;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [RW-1:0]            rd_data;
  logic                     init_busy;

  bw_r_frf_mp #(
    .HALF_W (HALF_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) dut (
    .rclk       (rclk),
    .rst        (rst),
    .init_req   (init_req),
    .rst_tri_en (rst_tri_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .init_busy  (init_busy)
  );

  always #5 rclk = ~rclk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic                     tri_en;
    logic [1:0]               wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DW-1:0]            wr_data;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
  } req_t;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_left;      // entries still to be zeroed; >0 means busy
  int            m_ptr;
  req_t          m_prev;      // request sampled one edge earlier
  logic [RW-1:0] m_rd;
  logic          m_busy;

  // Advance the model by one clock edge using the inputs present at that edge
  function automatic void model_step();
    bit                was_busy;
    logic [ADDR_W-1:0] a;
    if (rst) begin
      m_left = int'(DEPTH);
      m_ptr  = 0;
      m_prev = '0;
      m_rd   = '0;
    end else begin
      was_busy = (m_left > 0);
      if (was_busy) begin
        m_mem[m_ptr] = '0;
        m_ptr++;
        m_left--;
      end else if (!m_prev.tri_en) begin
        if (m_prev.wr_en[1]) m_mem[m_prev.wr_addr][DW-1:HALF_W] = m_prev.wr_data[DW-1:HALF_W];
        if (m_prev.wr_en[0]) m_mem[m_prev.wr_addr][HALF_W-1:0]  = m_prev.wr_data[HALF_W-1:0];
      end
      // Reading after the write gives the bypass result directly
      m_rd = '0;
      if (!was_busy) begin
        for (int p = 0; p < NUM_RD; p++) begin
          if (m_prev.rd_en[p]) begin
            a = m_prev.rd_addr[p*ADDR_W +: ADDR_W];
            m_rd[p*DW +: DW] = m_mem[a];
          end
        end
      end
      if (!was_busy && init_req) begin
        m_left = int'(DEPTH);
        m_ptr  = 0;
      end
      m_prev = '{tri_en: rst_tri_en, wr_en: wr_en, wr_addr: wr_addr,
                 wr_data: wr_data, rd_en: rd_en, rd_addr: rd_addr};
    end
    m_busy = (m_left > 0);
  endfunction

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: model updates at the edge, DUT is compared at the falling edge
  task automatic tick();
    @(posedge rclk);
    model_step();
    @(negedge rclk);
    chk("rd_data", rd_data, m_rd);
    chk("init_busy", RW'(init_busy), RW'(m_busy));
  endtask

  task automatic idle();
    init_req   = 1'b0;
    rst_tri_en = 1'b0;
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    rd_en      = '0;
    rd_addr    = '0;
  endtask

  // Counts cycles with init_busy high, starting with the current one
  task automatic count_busy(output int n);
    n = init_busy ? 1 : 0;
    for (int k = 0; k < 400 && init_busy; k++) begin
      tick();
      if (init_busy) n++;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]        wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
    logic              tri_en;
    logic [NUM_RD-1:0] rd_en;
    logic [DW-1:0]     exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int            n;
    logic [DW-1:0] v5;
    logic [DW-1:0] exp_v;
    int            ra[5];

    vecs[0] = '{2'b11, 7'h05, 78'h3A5A5A5A5_0F0F0F0F1, 1'b0, 2'b11, 78'h3A5A5A5A5_0F0F0F0F1};
    vecs[1] = '{2'b11, 7'h09, '1, 1'b1, 2'b11, '0};
    vecs[2] = '{2'b10, 7'h0C, {39'h12_3456_789A, 39'h55_5555_5555}, 1'b0, 2'b11,
                {39'h12_3456_789A, 39'h0}};
    vecs[3] = '{2'b01, 7'h0C, {39'h7F_FFFF_FFFF, 39'h0A_BCDE_F012}, 1'b0, 2'b11,
                {39'h12_3456_789A, 39'h0A_BCDE_F012}};
    vecs[4] = '{2'b00, 7'h05, '1, 1'b0, 2'b11, 78'h3A5A5A5A5_0F0F0F0F1};
    vecs[5] = '{2'b11, 7'h7F, '1, 1'b0, 2'b10, '1};
    vecs[6] = '{2'b11, 7'h00, {39'h00_0000_0001, 39'h40_0000_0000}, 1'b0, 2'b01,
                {39'h00_0000_0001, 39'h40_0000_0000}};
    ra = '{0, 1, 2, 3, 9};

    // Reset, then the power-up init window
    idle();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    count_busy(n);
    chk("busy_len_after_rst", RW'(n), RW'(DEPTH));

    // Every entry reads zero after init
    for (int a = 0; a < int'(DEPTH); a++) begin
      rd_en   = '1;
      rd_addr = {ADDR_W'(int'(DEPTH) - 1 - a), ADDR_W'(a)};
      tick();
    end
    idle();
    tick();
    tick();

    // Vector table: write, read the same entry on both ports, check 2 cycles later
    foreach (vecs[i]) begin
      idle();
      wr_en      = vecs[i].wr_en;
      wr_addr    = vecs[i].addr;
      wr_data    = vecs[i].data;
      rst_tri_en = vecs[i].tri_en;
      tick();
      idle();
      rd_en   = vecs[i].rd_en;
      rd_addr = {vecs[i].addr, vecs[i].addr};
      tick();
      idle();
      tick();
      for (int p = 0; p < int'(NUM_RD); p++) begin
        exp_v = vecs[i].rd_en[p] ? vecs[i].exp : '0;
        chk($sformatf("vec%0d_port%0d", i, p), RW'(rd_data[p*DW +: DW]), RW'(exp_v));
      end
    end

    // Low-half write with both ports reading the same entry in the same cycle
    v5 = vecs[0].exp;
    idle();
    wr_en   = 2'b01;
    wr_addr = 7'h05;
    wr_data = DW'(1);
    rd_en   = 2'b11;
    rd_addr = {7'h05, 7'h05};
    tick();
    idle();
    tick();
    exp_v = {v5[DW-1:HALF_W], 39'h1};
    chk("bypass_port0", RW'(rd_data[0 +: DW]), RW'(exp_v));
    chk("bypass_port1", RW'(rd_data[DW +: DW]), RW'(exp_v));

    // init_req from READY; a second request mid-init must not extend it
    for (int e = 0; e < 4; e++) begin
      idle();
      wr_en   = 2'b11;
      wr_addr = ADDR_W'(e);
      wr_data = DW'({$urandom(), $urandom(), $urandom()});
      tick();
    end
    idle();
    init_req = 1'b1;
    wr_en    = 2'b11;
    wr_addr  = 7'h09;
    wr_data  = '1;
    tick();
    idle();
    n = init_busy ? 1 : 0;
    for (int k = 0; k < 400 && init_busy; k++) begin
      if (n == 50) begin
        init_req = 1'b1;
        wr_en    = 2'b11;
        wr_addr  = 7'h09;
        wr_data  = '1;
      end
      tick();
      idle();
      if (init_busy) n++;
    end
    chk("busy_len_init_req", RW'(n), RW'(DEPTH));
    foreach (ra[i]) begin
      idle();
      rd_en   = 2'b11;
      rd_addr = {ADDR_W'(ra[i]), ADDR_W'(ra[i])};
      tick();
      idle();
      tick();
      chk($sformatf("zero_after_init_%0d", ra[i]), rd_data, '0);
    end

    // Reset in the middle of init restarts the full window
    idle();
    init_req = 1'b1;
    tick();
    idle();
    repeat (60) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(n);
    chk("busy_len_mid_rst", RW'(n), RW'(DEPTH));

    // Random traffic, mostly on a small address window to hit bypass often
    for (int k = 0; k < 800; k++) begin
      rst_tri_en = ($urandom_range(0, 7) == 0);
      wr_en      = 2'($urandom());
      wr_addr    = (k % 4 == 0) ? ADDR_W'($urandom_range(0, DEPTH - 1))
                                : ADDR_W'($urandom_range(0, 7));
      wr_data    = DW'({$urandom(), $urandom(), $urandom()});
      rd_en      = NUM_RD'($urandom());
      rd_addr    = {ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7))};
      init_req   = ($urandom_range(0, 299) == 0);
      tick();
    end
    idle();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bw_r_frf_mp.md
Name: bw_r_frf_mp

Overview:
- Parametrised, multi-read-port successor of the single R/W port floating-point register file.
- Storage is split into two independently writable halves, high and low; each half carries data plus ECC bits, and the data is treated as opaque.
- Provides one write port and NUM_RD read ports, all registered in and out, with defined same-cycle write-to-read bypass.
- A hardware init sequencer zeroes the whole array after reset or on request; it sits between the FFU datapath and the FP register storage.

Parameters:
- HALF_W, 39, width of one half-word (32 data + 7 ECC).
- DEPTH, 128, number of entries.
- ADDR_W, 7, address width; must equal clog2(DEPTH).
- NUM_RD, 2, number of read ports (1..4).

Ports:
- rclk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- init_req  in  1  pulse: re-run array zeroing; honoured only in READY.
- rst_tri_en  in  1  write block; registered with the input stage.
- wr_en  in  2  half write enables: [1]=high, [0]=low.
- wr_addr  in  ADDR_W  write entry.
- wr_data  in  2*HALF_W  write data: [2*HALF_W-1:HALF_W]=high, [HALF_W-1:0]=low.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*ADDR_W  port p occupies slice [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*2*HALF_W  port p occupies slice [p*2*HALF_W +: 2*HALF_W].
- init_busy  out  1  high while the array is being zeroed.

Behaviour:
Reset:
- One clock (rclk); reset is synchronous and active-high (rst).
- While rst=1: FSM=INIT, init counter=0, all input-stage registers cleared, rd_data=0, init_busy=1.
Pipeline:
- Cycle 0: all inputs sampled into the input stage (S1).
- Cycle 1: array access; writes commit at the end of this cycle; read data is captured into the output register.
- Read latency is 2: rd_addr presented at edge N gives rd_data valid after edge N+2.
- rd_en=0 in S1 gives rd_data slice = 0 at the next output update.
- Outputs hold their value only through the output register; no combinational path from any input to rd_data.
Writes:
- A half is written iff its wr_en bit=1 in S1, rst_tri_en in S1=0, and FSM=READY.
- wr_en=2'b00 means no write.
Bypass:
- If port p reads wr_addr in the same S1 cycle as a committing write, each written half returns the new data.
- Unwritten halves return the old contents.
- All read ports may read the same address; no conflicts and no X.
FSM states:
- INIT: writes zero to both halves at counter address, one entry per cycle, counter +1.
  - At counter=DEPTH-1: write that entry, go to READY, counter wraps to 0.
  - init_busy=1; external writes dropped; reads return 0.
- READY: normal operation; init_busy=0.
  - init_req=1 goes to INIT next cycle with counter=0.
  - A write in S1 in that same cycle still commits.
- init_req while in INIT is ignored; it does not restart.
- rst mid-INIT restarts from address 0.
- Init duration: exactly DEPTH cycles after rst falls; init_busy drops at edge DEPTH.
Constraints:
- Out-of-range addresses are not possible (DEPTH=2^ADDR_W is required; elaboration assertion).
- rst_tri_en does not affect the init sequencer or reads.

Decomposition:
- Package bw_r_frf_pkg:
  - FSM state encoding: INIT=1'b0, READY=1'b1.
  - Default HALF_W/DEPTH/ADDR_W constants.
  - Half-select index constants HI=1, LO=0.
- Sub-module bw_r_frf_bank: one half-array with one write port and NUM_RD registered read ports, including per-port bypass; instantiated twice.
- Top level holds the input stage, the FSM/counter, and the write qualification.

Test Plan:
- Reset then idle: rst high 3 cycles, then low. Required: init_busy=1 for exactly 128 cycles after rst falls, then 0. A read of every address returns 78'h0.
- Basic write/read: write addr 7'h05, wr_en=2'b11, data 78'h3A5A5A5A5_0F0F0F0F1. Read port 0 at addr 5 two cycles later. Required: rd_data[77:0] equals that value 2 cycles after rd_addr is presented.
- Half write plus bypass: with entry 5 holding the value above, same cycle write addr 5, wr_en=2'b01, low=39'h1; port 0 and port 1 both read addr 5. Required: both return {old high, 39'h1}.
- Write gating: write addr 9 with rst_tri_en=1, or during INIT. Required: a subsequent read of addr 9 returns 0. rd_en=0 on any port returns 0 regardless of contents.
- init_req from READY after entries 0..3 are written. Required: init_busy=1 for 128 cycles, then all entries read 0. A second init_req at cycle 50 of INIT does not extend the busy window.
- rst asserted at init counter=60. Required: after rst falls, init_busy stays high for exactly 128 more cycles.
